// File: rtl/ms_sec_countdown_if.sv
// Interface bundle for ms_sec_countdown: the control and tick inputs, and the time/status outputs.
// The master modport is the controlling side. The slave modport is the countdown block.
interface ms_sec_countdown_if;
   logic       ms_tick;
   logic       load;
   logic [3:0] load_tens;
   logic [3:0] load_ones;
   logic       start;
   logic       pause;
   logic       lfsr_enable;
   logic [3:0] sec_tens;
   logic [3:0] sec_ones;
   logic       running;
   logic       time_up;
   logic       warn;

   modport master (
      output ms_tick, load, load_tens, load_ones, start, pause,
      input  lfsr_enable, sec_tens, sec_ones, running, time_up, warn
   );

   modport slave (
      input  ms_tick, load, load_tens, load_ones, start, pause,
      output lfsr_enable, sec_tens, sec_ones, running, time_up, warn
   );
endinterface

// File: rtl/ms_sec_countdown.sv
// Two-digit BCD seconds countdown that is paced by 1 ms ticks and gates the upstream ms timer.
// Optional macro TIMER_WARN_EN enables the registered low-time warn output.
module ms_sec_countdown #(
   parameter int unsigned MS_PER_SEC = 1000,
   parameter int unsigned MS_W       = 10,
   parameter int unsigned WARN_SECS  = 5
) (
   input logic                  clk,
   input logic                  rst,
   ms_sec_countdown_if.slave    bus
);

   typedef enum logic [1:0] {StIdle, StRun, StPaused, StDone} state_e;

   localparam logic [MS_W-1:0] MsLast = MS_W'(MS_PER_SEC - 1);

   state_e          state_q, state_d;
   logic [MS_W-1:0] ms_cnt_q, ms_cnt_d;
   logic [3:0]      tens_q, tens_d;
   logic [3:0]      ones_q, ones_d;
   logic            run_q, run_d;
   logic            time_up_q, time_up_d;
   logic            digits_zero;
   logic            last_sec;

   function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

   assign digits_zero = (tens_q == 4'd0) && (ones_q == 4'd0);
   // Treat 00 as the last second too, so the digits can never wrap below 00.
   assign last_sec    = (tens_q == 4'd0) && (ones_q <= 4'd1);

   always_comb begin
      state_d   = state_q;
      ms_cnt_d  = ms_cnt_q;
      tens_d    = tens_q;
      ones_d    = ones_q;
      time_up_d = 1'b0;

      if (bus.load) begin
         state_d  = StIdle;
         ms_cnt_d = '0;
         tens_d   = clamp_bcd(bus.load_tens);
         ones_d   = clamp_bcd(bus.load_ones);
      end else begin
         unique case (state_q)
            StIdle, StPaused: begin
               if (bus.start) begin
                  if (digits_zero) begin
                     state_d   = StDone;
                     time_up_d = 1'b1;
                  end else begin
                     state_d = StRun;
                  end
               end
            end
            StRun: begin
               if (!bus.start && bus.pause) begin
                  state_d = StPaused;
               end
               // The tick is still counted on the edge where pause is sampled.
               if (bus.ms_tick) begin
                  if (ms_cnt_q == MsLast) begin
                     ms_cnt_d = '0;
                     if (last_sec) begin
                        tens_d    = 4'd0;
                        ones_d    = 4'd0;
                        state_d   = StDone;
                        time_up_d = 1'b1;
                     end else if (ones_q == 4'd0) begin
                        ones_d = 4'd9;
                        tens_d = tens_q - 4'd1;
                     end else begin
                        ones_d = ones_q - 4'd1;
                     end
                  end else begin
                     ms_cnt_d = ms_cnt_q + MS_W'(1);
                  end
               end
            end
            StDone: begin
            end
            default: state_d = StIdle;
         endcase
      end

      run_d = (state_d == StRun);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= StIdle;
         ms_cnt_q  <= '0;
         tens_q    <= 4'd0;
         ones_q    <= 4'd0;
         run_q     <= 1'b0;
         time_up_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ms_cnt_q  <= ms_cnt_d;
         tens_q    <= tens_d;
         ones_q    <= ones_d;
         run_q     <= run_d;
         time_up_q <= time_up_d;
      end
   end

`ifdef TIMER_WARN_EN
   logic       warn_q, warn_d;
   logic [6:0] secs_d;

   always_comb begin
      secs_d = (7'(tens_d) * 7'd10) + 7'(ones_d);
      warn_d = ((state_d == StRun) || (state_d == StPaused)) &&
               (secs_d <= 7'(WARN_SECS)) && (secs_d != 7'd0);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         warn_q <= 1'b0;
      end else begin
         warn_q <= warn_d;
      end
   end

   assign bus.warn = warn_q;
`else
   assign bus.warn = 1'b0;
`endif

   assign bus.lfsr_enable = run_q;
   assign bus.running     = run_q;
   assign bus.sec_tens    = tens_q;
   assign bus.sec_ones    = ones_q;
   assign bus.time_up     = time_up_q;

endmodule
